// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: EX-stage issue controller that decodes one op per handshake, drives the
// external combinational ALU from registered operands, waits a settle time (MUL_CYCLES
// for mul, 1 otherwise), captures the result and presents it downstream with valid/ready.
// Ports: clk_i/rst_i (sync active-high); in_valid_i/in_ready_o + ALUOp_i, funct_i, ALUSrc_i,
// rs1_data_i, rs2_data_i, imm_i, rd_i (op in); alu_data1_o/alu_data2_o/alu_ctrl_o (to ALU),
// alu_data_i (from ALU); out_valid_o/out_ready_i + result_o, rd_o, illegal_o (result out).
// Option: ALU_ISSUE_BYPASS_EN lets DONE retire and accept in the same cycle.
module alu_issue_ctrl #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        ALUOp_i,
  input  logic [9:0]        funct_i,
  input  logic              ALUSrc_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rd_i,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  output logic [2:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_o,
  output logic              illegal_o
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        w_ctrl;
  logic              w_ill, w_accept, w_fire;
  logic [DATA_W-1:0] r_d1, r_d2, r_res;
  logic [2:0]        r_ctrl;
  logic [4:0]        r_rd_q, r_rd;
  logic              r_ill_q, r_ill;
  // Unsupported combinations fall back to the 'and' code with the illegal flag raised.
  always_comb begin
    w_ctrl = 3'b000;
    w_ill  = 1'b0;
    case (ALUOp_i)
      2'b00: w_ctrl = 3'b010;
      2'b01: w_ctrl = 3'b110;
      2'b10:
        case (funct_i)
          10'b0000000_000: w_ctrl = 3'b010;
          10'b0100000_000: w_ctrl = 3'b110;
          10'b0000001_000: w_ctrl = 3'b100;
          10'b0000000_111: w_ctrl = 3'b000;
          10'b0000000_110: w_ctrl = 3'b001;
          default:         w_ill  = 1'b1;
        endcase
      default:
        case (funct_i[2:0])
          3'b000:  w_ctrl = 3'b010;
          3'b111:  w_ctrl = 3'b000;
          3'b110:  w_ctrl = 3'b001;
          default: w_ill  = 1'b1;
        endcase
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next      = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_next = EXEC;
      end
      EXEC: if (r_cnt == '0) w_next = DONE;
      DONE: begin
        out_valid_o = 1'b1;
`ifdef ALU_ISSUE_BYPASS_EN
        in_ready_o = out_ready_i;
        if (out_ready_i) w_next = in_valid_i ? EXEC : IDLE;
`else
        if (out_ready_i) w_next = IDLE;
`endif
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_accept = in_valid_i & in_ready_o;
  assign w_fire   = (r_state == EXEC) && (r_cnt == '0);
  // An accept always comes from IDLE or DONE, never EXEC, so it cannot collide with the countdown.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_d1    <= '0;
      r_d2    <= '0;
      r_ctrl  <= 3'b000;
      r_rd_q  <= '0;
      r_ill_q <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_rd    <= '0;
      r_ill   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_d1    <= rs1_data_i;
        r_d2    <= ALUSrc_i ? imm_i : rs2_data_i;
        r_ctrl  <= w_ctrl;
        r_rd_q  <= rd_i;
        r_ill_q <= w_ill;
        r_cnt   <= (w_ctrl == 3'b100) ? CW'(MUL_CYCLES - 1) : '0;
      end else if (r_state == EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire) begin
        r_res <= alu_data_i;
        r_rd  <= r_rd_q;
        r_ill <= r_ill_q;
      end
    end
  end
  assign alu_data1_o = r_d1;
  assign alu_data2_o = r_d2;
  assign alu_ctrl_o  = r_ctrl;
  assign result_o    = r_res;
  assign rd_o        = r_rd;
  assign illegal_o   = r_ill;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a transaction-level model and a stub ALU.
module tb_alu_issue_ctrl;
  localparam int MC = 3;
`ifdef ALU_ISSUE_BYPASS_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic [1:0]  ALUOp_i = '0;
  logic [9:0]  funct_i = '0;
  logic        ALUSrc_i = 1'b0;
  logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] alu_data1_o, alu_data2_o, alu_data_i, result_o;
  logic [2:0]  alu_ctrl_o;
  logic        out_valid_o, out_ready_i = 1'b1, illegal_o;
  logic [4:0]  rd_o;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  alu_issue_ctrl #(.DATA_W(32), .MUL_CYCLES(MC)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .ALUSrc_i(ALUSrc_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rd_i(rd_i), .alu_data1_o(alu_data1_o),
    .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o), .alu_data_i(alu_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .rd_o(rd_o), .illegal_o(illegal_o));
  function automatic logic [3:0] dec(input logic [1:0] op, input logic [9:0] f);
    if (op == 2'd0) return 4'b0_010;
    if (op == 2'd1) return 4'b0_110;
    if (op == 2'd2) begin
      if (f == 10'b0000000_000) return 4'b0_010;
      if (f == 10'b0100000_000) return 4'b0_110;
      if (f == 10'b0000001_000) return 4'b0_100;
      if (f == 10'b0000000_111) return 4'b0_000;
      if (f == 10'b0000000_110) return 4'b0_001;
      return 4'b1_000;
    end
    if (f[2:0] == 3'b000) return 4'b0_010;
    if (f[2:0] == 3'b111) return 4'b0_000;
    if (f[2:0] == 3'b110) return 4'b0_001;
    return 4'b1_000;
  endfunction
  function automatic logic [31:0] alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (c == 3'b010) return a + b;
    if (c == 3'b110) return a - b;
    if (c == 3'b100) return p[31:0];
    if (c == 3'b000) return a & b;
    if (c == 3'b001) return a | b;
    return 32'h0;
  endfunction
  assign alu_data_i = alu(alu_ctrl_o, alu_data1_o, alu_data2_o);
  int          m_busy = 0;
  logic        m_valid = 0, m_ill = 0, p_ill = 0;
  logic [31:0] m_res = 0, p_res = 0, m_d1 = 0, m_d2 = 0;
  logic [4:0]  m_rd = 0, p_rd = 0;
  logic [2:0]  m_ctrl = 0;
  function automatic logic exp_rdy();
`ifdef ALU_ISSUE_BYPASS_EN
    return (m_busy == 0) && (!m_valid || out_ready_i);
`else
    return (m_busy == 0) && !m_valid;
`endif
  endfunction
  always @(posedge clk) begin
    logic       rdy;
    logic [3:0] d;
    if (rst_i) begin
      m_busy = 0; m_valid = 0; m_ill = 0; m_res = 0; m_rd = 0;
      m_ctrl = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      rdy = exp_rdy();
      if (m_valid && out_ready_i) m_valid = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1; m_res = p_res; m_rd = p_rd; m_ill = p_ill;
        end
      end
      if (in_valid_i && rdy) begin
        d = dec(ALUOp_i, funct_i);
        m_ctrl = d[2:0];
        m_d1 = rs1_data_i;
        m_d2 = ALUSrc_i ? imm_i : rs2_data_i;
        p_res = alu(m_ctrl, m_d1, m_d2);
        p_rd = rd_i;
        p_ill = d[3];
        m_busy = (m_ctrl == 3'b100) ? MC : 1;
      end
    end
  end
  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_i) begin
      cmp("in_ready", 32'(in_ready_o), 32'(exp_rdy()));
      cmp("out_valid", 32'(out_valid_o), 32'(m_valid));
      cmp("result", result_o, m_res);
      cmp("rd", 32'(rd_o), 32'(m_rd));
      cmp("illegal", 32'(illegal_o), 32'(m_ill));
      cmp("alu_ctrl", 32'(alu_ctrl_o), 32'(m_ctrl));
      cmp("alu_d1", alu_data1_o, m_d1);
      cmp("alu_d2", alu_data2_o, m_d2);
    end
  end
  task automatic set_op(input logic [1:0] op, input logic [9:0] f, input logic src,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [4:0] rd);
    ALUOp_i = op; funct_i = f; ALUSrc_i = src;
    rs1_data_i = a; rs2_data_i = b; imm_i = im; rd_i = rd;
  endtask
  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready_o;
    end
    if (!ok) cmp("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask
  task automatic issue(input string nm, input logic [1:0] op, input logic [9:0] f, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] rd, input logic [2:0] ectrl, input logic [31:0] eres,
                       input logic eill, input int elat);
    int n;
    @(posedge clk); #1;
    set_op(op, f, src, a, b, im, rd);
    in_valid_i = 1'b1;
    wait_accept();
    in_valid_i = 1'b0;
    n = 0;
    for (int k = 1; k <= 60 && n == 0; k++) begin
      @(negedge clk);
      if (k == 1) cmp({nm, "_ctrl"}, 32'(alu_ctrl_o), 32'(ectrl));
      if (out_valid_o) n = k;
    end
    cmp({nm, "_latency"}, n, elat);
    cmp({nm, "_result"}, result_o, eres);
    cmp({nm, "_illegal"}, 32'(illegal_o), 32'(eill));
    cmp({nm, "_rd"}, 32'(rd_o), 32'(rd));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t[4];
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    cmp("reset_in_ready", 32'(in_ready_o), 32'd1);
    cmp("reset_out_valid", 32'(out_valid_o), 32'd0);
    cmp("reset_ctrl", 32'(alu_ctrl_o), 32'd0);
    cmp("reset_result", result_o, 32'd0);
    issue("add", 2'b10, 10'b0000000_000, 0, 5, 7, 0, 5'd1, 3'b010, 32'd12, 0, 2);
    issue("mul", 2'b10, 10'b0000001_000, 0, 6, 7, 0, 5'd2, 3'b100, 32'd42, 0, MC + 1);
    issue("ori", 2'b11, 10'b0000000_110, 1, 32'hF0, 32'h1234, 32'h0F, 5'd3, 3'b001, 32'hFF, 0, 2);
    issue("sub0", 2'b01, 10'b1010101_011, 0, 3, 5, 0, 5'd4, 3'b110, 32'hFFFF_FFFE, 0, 2);
    issue("ill_r", 2'b10, 10'b1111111_101, 0, 32'hF0F0, 32'hFF00, 0, 5'd5, 3'b000, 32'hF000, 1, 2);
    issue("subr", 2'b10, 10'b0100000_000, 0, 10, 3, 99, 5'd6, 3'b110, 32'd7, 0, 2);
    issue("andi", 2'b11, 10'b0000000_111, 1, 32'hFF0F, 32'h0, 32'h0FF0, 5'd7, 3'b000, 32'h0F00, 0, 2);
    issue("ill_i", 2'b11, 10'b0000000_001, 0, 32'h3C, 32'h0F, 0, 5'd8, 3'b000, 32'h0C, 1, 2);
    issue("mulw", 2'b10, 10'b0000001_000, 0, 32'h10000, 32'h10003, 0, 5'd9, 3'b100, 32'h30000, 0, MC + 1);
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    issue("stall", 2'b00, 10'b0, 0, 100, 23, 0, 5'd10, 3'b010, 32'd123, 0, 2);
    @(posedge clk); #1;
    set_op(2'b10, 10'b0000001_000, 0, 9, 9, 0, 5'd31);
    in_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      cmp("stall_valid", 32'(out_valid_o), 32'd1);
      cmp("stall_result", result_o, 32'd123);
      cmp("stall_rd", 32'(rd_o), 32'd10);
      cmp("stall_in_ready", 32'(in_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    set_op(2'b10, 10'b0000001_000, 0, 4, 4, 0, 5'd11);
    in_valid_i = 1'b1;
    wait_accept();
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    cmp("rst_exec_valid", 32'(out_valid_o), 32'd0);
    cmp("rst_exec_ctrl", 32'(alu_ctrl_o), 32'd0);
    cmp("rst_exec_in_ready", 32'(in_ready_o), 32'd1);
    cmp("rst_exec_result", result_o, 32'd0);
    issue("post_rst", 2'b00, 10'b0, 0, 1, 1, 0, 5'd12, 3'b010, 32'd2, 0, 2);
    @(posedge clk); #1;
    set_op(2'b00, 10'b0, 0, 1, 1, 0, 5'd13);
    in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
        @(negedge clk);
        ok = in_ready_o;
      end
      if (!ok) cmp("stream_timeout", 32'd0, 32'd1);
      t[i] = cyc;
      @(posedge clk); #1;
      if (i < 3) set_op(2'b00, 10'b0, 0, 32'(i + 2), 32'd10, 0, 5'(14 + i));
      else in_valid_i = 1'b0;
    end
    for (int i = 1; i < 4; i++) cmp("stream_gap", t[i] - t[i-1], GAP);
    repeat (6) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
